// File: rtl/wash_pkg.sv
// Shared types and constants for the wash agitation controller and the stepper sequencer.
package wash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DWELL,
        ST_PAUSED,
        ST_DONE
    } wash_state_t;

    localparam logic [3:0] COILS_OFF = 4'b0000;

    // Entry 0 is the least-significant nibble: A, DA, D, DC, C, CB, B, BA.
    localparam logic [7:0][3:0] STEP_TABLE = {
        4'b0011, 4'b0010, 4'b0110, 4'b0100,
        4'b1100, 4'b1000, 4'b1001, 4'b0001
    };

    function automatic logic [3:0] step_pattern(input logic [2:0] idx);
        return STEP_TABLE[idx];
    endfunction

endpackage

// File: rtl/wash_agitator_ctrl_stepper_seq.sv
// Unipolar 4-coil stepper sequencer: step index, full/half increment, registered coil drive.
module stepper_seq
    import wash_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic       seg_start,
    input  logic       tick,
    input  logic       drive,
    input  logic       reverse,
    input  logic       half_step,
    output logic [3:0] coils
);

    logic [2:0] idx_q;
    logic [2:0] idx_d;
    logic [2:0] inc;
    logic       half_q;

    // Step size is latched per segment so mid-segment HalfStep changes wait for the next start.
    always_comb begin
        inc   = half_q ? 3'd1 : 3'd2;
        idx_d = idx_q;
        if (seg_start) begin
            idx_d = 3'd0;
        end else if (tick) begin
            idx_d = reverse ? (idx_q - inc) : (idx_q + inc);
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            idx_q  <= 3'd0;
            half_q <= 1'b0;
            coils  <= COILS_OFF;
        end else begin
            idx_q <= idx_d;
            if (seg_start) begin
                half_q <= half_step;
            end
            coils <= drive ? step_pattern(idx_d) : COILS_OFF;
        end
    end

endmodule

// File: rtl/wash_agitator_ctrl.sv
// Wash-phase agitation controller: alternating-direction stepper segments separated by coil-off dwells.
//   state  | meaning
//   IDLE   | waiting for a Start rising edge, coils off
//   RUN    | driving the stepper for the current segment
//   DWELL  | coils off between segments
//   PAUSED | counters and coils frozen; saved_q holds RUN or DWELL
//   DONE   | phase complete, Done held until Start drops
module wash_agitator_ctrl
    import wash_pkg::*;
#(
    parameter int NUM_SEG   = 6,
    parameter int SEG_LEN   = 100,
    parameter int DWELL_LEN = 4,
    parameter int STEP_DIV  = 1,
    parameter int CNT_W     = 16,
    localparam int SEG_W    = $clog2(NUM_SEG) + 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Pause,
    input  logic             HalfStep,
    output logic [3:0]       Coils,
    output logic             Reverse,
    output logic             Busy,
    output logic             Done,
    output logic [SEG_W-1:0] SegIdx
);

    localparam logic [CNT_W-1:0] SEG_LAST   = CNT_W'(SEG_LEN - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'((DWELL_LEN > 0) ? (DWELL_LEN - 1) : 0);
    localparam logic [SEG_W-1:0] SEG_FINAL  = SEG_W'(NUM_SEG - 1);

    wash_state_t      state_q, state_d;
    wash_state_t      saved_q, saved_d;
    wash_state_t      eff;
    logic [CNT_W-1:0] seg_cnt_q, seg_cnt_d;
    logic [CNT_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [SEG_W-1:0] seg_idx_d;
    logic             rev_d;
    logic             start_low_q;
    logic             load_seg;
    logic             tick;
    logic             drive;

    // A PAUSED cycle with Pause low behaves exactly like the saved state, so each pause cycle costs one cycle.
    always_comb begin
        state_d     = state_q;
        saved_d     = saved_q;
        seg_cnt_d   = seg_cnt_q;
        dwell_cnt_d = dwell_cnt_q;
        div_cnt_d   = div_cnt_q;
        seg_idx_d   = SegIdx;
        rev_d       = Reverse;
        load_seg    = 1'b0;
        tick        = 1'b0;
        eff         = (state_q == ST_PAUSED) ? saved_q : state_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_low_q && Start) begin
                    load_seg  = 1'b1;
                    seg_idx_d = '0;
                    rev_d     = 1'b0;
                end
            end
            ST_RUN, ST_DWELL, ST_PAUSED: begin
                if (!Start) begin
                    state_d     = ST_IDLE;
                    seg_idx_d   = '0;
                    rev_d       = 1'b0;
                    seg_cnt_d   = '0;
                    dwell_cnt_d = '0;
                    div_cnt_d   = '0;
                end else if (Pause) begin
                    state_d = ST_PAUSED;
                    saved_d = eff;
                end else if (eff == ST_RUN) begin
                    state_d = ST_RUN;
                    if (seg_cnt_q == '0) begin
                        if (SegIdx == SEG_FINAL) begin
                            state_d = ST_DONE;
                        end else if (DWELL_LEN > 0) begin
                            state_d     = ST_DWELL;
                            dwell_cnt_d = DWELL_LAST;
                        end else begin
                            load_seg  = 1'b1;
                            seg_idx_d = SegIdx + 1'b1;
                            rev_d     = ~Reverse;
                        end
                    end else begin
                        seg_cnt_d = seg_cnt_q - 1'b1;
                        if (div_cnt_q == '0) begin
                            tick      = 1'b1;
                            div_cnt_d = DIV_LAST;
                        end else begin
                            div_cnt_d = div_cnt_q - 1'b1;
                        end
                    end
                end else begin
                    state_d = ST_DWELL;
                    if (dwell_cnt_q == '0) begin
                        load_seg  = 1'b1;
                        seg_idx_d = SegIdx + 1'b1;
                        rev_d     = ~Reverse;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q - 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (!Start) begin
                    state_d   = ST_IDLE;
                    seg_idx_d = '0;
                    rev_d     = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_seg) begin
            state_d   = ST_RUN;
            seg_cnt_d = SEG_LAST;
            div_cnt_d = DIV_LAST;
        end

        drive = (state_d == ST_RUN) || ((state_d == ST_PAUSED) && (saved_d == ST_RUN));
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            saved_q     <= ST_IDLE;
            seg_cnt_q   <= '0;
            dwell_cnt_q <= '0;
            div_cnt_q   <= '0;
            SegIdx      <= '0;
            Reverse     <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            start_low_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            saved_q     <= saved_d;
            seg_cnt_q   <= seg_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            div_cnt_q   <= div_cnt_d;
            SegIdx      <= seg_idx_d;
            Reverse     <= rev_d;
            Busy        <= (state_d == ST_RUN) || (state_d == ST_DWELL) || (state_d == ST_PAUSED);
            Done        <= (state_d == ST_DONE);
            // Cleared by reset, so Start held high through reset needs a low sample before it relaunches.
            start_low_q <= ~Start;
        end
    end

    stepper_seq u_stepper (
        .CLK       (CLK),
        .Reset     (Reset),
        .seg_start (load_seg),
        .tick      (tick),
        .drive     (drive),
        .reverse   (Reverse),
        .half_step (HalfStep),
        .coils     (Coils)
    );

endmodule

// File: tb/tb_wash_agitator_ctrl.sv
// Bench for wash_agitator_ctrl with a default instance and a half-step, no-dwell, divided-rate instance.
`timescale 1ns/1ps
module tb_wash_agitator_ctrl;

    localparam int A_NSEG = 6, A_SLEN = 100, A_DLEN = 4, A_SDIV = 1;
    localparam int B_NSEG = 3, B_SLEN = 24,  B_DLEN = 0, B_SDIV = 3;

    typedef struct packed {
        logic [1:0]  phase;
        logic [15:0] t;
        logic        armed;
        logic        half;
    } mst_t;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Pause = 1'b0;
    logic        HalfStep = 1'b0;
    logic [3:0]  coils_a, coils_b;
    logic        rev_a, rev_b, busy_a, busy_b, done_a, done_b;
    logic [3:0]  seg_a;
    logic [2:0]  seg_b;
    logic [14:0] obs_a, obs_b, exp_a, exp_b;
    mst_t        m_a = '0;
    mst_t        m_b = '0;
    logic [3:0]  pat    [8] = '{4'h1, 4'h9, 4'h8, 4'hC, 4'h4, 4'h6, 4'h2, 4'h3};
    logic [3:0]  fwd_fs [4] = '{4'h1, 4'h8, 4'h4, 4'h2};
    logic [3:0]  rev_fs [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
    int          checks = 0;
    int          errors = 0;

    always #5 CLK = ~CLK;

    wash_agitator_ctrl #(.NUM_SEG(A_NSEG), .SEG_LEN(A_SLEN), .DWELL_LEN(A_DLEN), .STEP_DIV(A_SDIV), .CNT_W(16)) dut_a (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Pause(Pause), .HalfStep(HalfStep),
        .Coils(coils_a), .Reverse(rev_a), .Busy(busy_a), .Done(done_a), .SegIdx(seg_a));

    wash_agitator_ctrl #(.NUM_SEG(B_NSEG), .SEG_LEN(B_SLEN), .DWELL_LEN(B_DLEN), .STEP_DIV(B_SDIV), .CNT_W(16)) dut_b (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Pause(Pause), .HalfStep(HalfStep),
        .Coils(coils_b), .Reverse(rev_b), .Busy(busy_b), .Done(done_b), .SegIdx(seg_b));

    assign obs_a = {coils_a, rev_a, busy_a, done_a, 4'b0000, seg_a};
    assign obs_b = {coils_b, rev_b, busy_b, done_b, 5'b00000, seg_b};

    // The phase is tracked as a count t of non-paused active cycles; every output follows from t.
    function automatic mst_t model_step(mst_t m, int nseg, int slen, int dlen,
                                        logic rst, logic start, logic pause, logic half);
        mst_t n;
        int per, total, t1;
        n = m;
        per = slen + dlen;
        total = nseg * slen + (nseg - 1) * dlen;
        if (rst) return '0;
        n.armed = ~start;
        case (m.phase)
            2'd0: if (m.armed && start) begin
                n.phase = 2'd1;
                n.t = '0;
                n.half = half;
            end
            2'd1: begin
                if (!start) begin
                    n.phase = 2'd0;
                end else if (!pause) begin
                    t1 = int'(m.t) + 1;
                    if (t1 >= total) begin
                        n.phase = 2'd2;
                    end else begin
                        n.t = 16'(t1);
                        if (t1 % per == 0) n.half = half;
                    end
                end
            end
            default: if (!start) n.phase = 2'd0;
        endcase
        return n;
    endfunction

    function automatic logic [14:0] model_out(mst_t m, int nseg, int slen, int dlen, int sdiv);
        int per, s, off, k, pos;
        logic [3:0] c;
        per = slen + dlen;
        s = int'(m.t) / per;
        off = int'(m.t) % per;
        c = 4'h0;
        if (m.phase == 2'd0) return '0;
        if (m.phase == 2'd2) return {4'h0, 1'((nseg - 1) % 2), 1'b0, 1'b1, 8'(nseg - 1)};
        if (off < slen) begin
            k = (off / sdiv) * (m.half ? 1 : 2);
            pos = (s % 2 == 1) ? (8 - k % 8) % 8 : k % 8;
            c = pat[pos];
        end
        return {c, 1'(s % 2), 1'b1, 1'b0, 8'(s)};
    endfunction

    always @(posedge CLK) begin
        m_a <= model_step(m_a, A_NSEG, A_SLEN, A_DLEN, Reset, Start, Pause, HalfStep);
        m_b <= model_step(m_b, B_NSEG, B_SLEN, B_DLEN, Reset, Start, Pause, HalfStep);
    end

    assign exp_a = model_out(m_a, A_NSEG, A_SLEN, A_DLEN, A_SDIV);
    assign exp_b = model_out(m_b, B_NSEG, B_SLEN, B_DLEN, B_SDIV);

    task automatic cycle();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic launch();
        Start = 1'b0;
        cycle();
        Start = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; Pause = 1'b0; HalfStep = 1'b0;
        repeat (3) cycle();
        checks++;
        if (obs_a !== 15'h0) begin errors++; $display("FAIL reset_a got=%h want=0000", obs_a); end
        checks++;
        if (obs_b !== 15'h0) begin errors++; $display("FAIL reset_b got=%h want=0000", obs_b); end
        Reset = 1'b0;
        Pause = 1'b1;
        cycle();
        Pause = 1'b0;
        checks++;
        if (obs_a !== exp_a) begin errors++; $display("FAIL idle_a got=%h want=%h", obs_a, exp_a); end
    endtask

    task automatic test_full_step();
        int n;
        n = 0;
        HalfStep = 1'b0;
        launch();
        checks++;
        if (coils_a !== 4'b0001 || busy_a !== 1'b1 || rev_a !== 1'b0 || seg_a !== 4'd0) begin
            errors++; $display("FAIL run_entry got=%h want coils=1 busy=1", obs_a);
        end
        while (done_a !== 1'b1 && n < 1000) begin
            if (n < 100) begin
                checks++;
                if (coils_a !== fwd_fs[n % 4]) begin errors++; $display("FAIL fwd_seq n=%0d got=%h want=%h", n, coils_a, fwd_fs[n % 4]); end
            end else if (n < 104) begin
                checks++;
                if (coils_a !== 4'b0000) begin errors++; $display("FAIL dwell_gap n=%0d got=%h want=0", n, coils_a); end
            end else if (n < 112) begin
                checks++;
                if (coils_a !== rev_fs[(n - 104) % 4] || rev_a !== 1'b1 || seg_a !== 4'd1) begin
                    errors++; $display("FAIL rev_seq n=%0d got=%h want coils=%h rev=1 seg=1", n, obs_a, rev_fs[(n - 104) % 4]);
                end
            end
            checks++;
            if (obs_a !== exp_a) begin errors++; $display("FAIL full_a n=%0d got=%h want=%h", n, obs_a, exp_a); end
            checks++;
            if (obs_b !== exp_b) begin errors++; $display("FAIL full_b n=%0d got=%h want=%h", n, obs_b, exp_b); end
            cycle(); n++;
        end
        checks++;
        if (n !== 620) begin errors++; $display("FAIL done_latency got=%0d want=620", n); end
        repeat (10) begin
            cycle();
            checks++;
            if (done_a !== 1'b1 || busy_a !== 1'b0 || coils_a !== 4'b0000) begin
                errors++; $display("FAIL done_hold got=%h want done=1 busy=0", obs_a);
            end
        end
        Start = 1'b0;
        cycle();
        checks++;
        if (done_a !== 1'b0 || obs_a !== 15'h0) begin errors++; $display("FAIL done_clear got=%h want=0000", obs_a); end
    endtask

    task automatic test_half_step();
        int n;
        logic [3:0] want;
        HalfStep = 1'b1;
        launch();
        for (n = 0; n < 150; n++) begin
            if (n < 2 * B_SLEN) begin
                want = (n < B_SLEN) ? pat[n / 3] : pat[(8 - (n - B_SLEN) / 3) % 8];
                checks++;
                if (coils_b !== want) begin errors++; $display("FAIL half_seq n=%0d got=%h want=%h", n, coils_b, want); end
            end
            checks++;
            if (obs_a !== exp_a) begin errors++; $display("FAIL half_a n=%0d got=%h want=%h", n, obs_a, exp_a); end
            checks++;
            if (obs_b !== exp_b) begin errors++; $display("FAIL half_b n=%0d got=%h want=%h", n, obs_b, exp_b); end
            cycle();
        end
        Start = 1'b0;
        cycle();
        HalfStep = 1'b0;
    endtask

    task automatic pause_run(input int p0, input int plen, input int exp_done);
        int n;
        logic [14:0] held;
        n = 0;
        held = '0;
        HalfStep = 1'b0;
        launch();
        while (done_a !== 1'b1 && n < 1200) begin
            Pause = (n >= p0 && n < p0 + plen);
            if (n == p0) held = obs_a;
            if (n > p0 && n <= p0 + plen) begin
                checks++;
                if (obs_a !== held || busy_a !== 1'b1) begin errors++; $display("FAIL pause_frozen n=%0d got=%h want=%h", n, obs_a, held); end
            end
            checks++;
            if (obs_a !== exp_a) begin errors++; $display("FAIL pause_a n=%0d got=%h want=%h", n, obs_a, exp_a); end
            checks++;
            if (obs_b !== exp_b) begin errors++; $display("FAIL pause_b n=%0d got=%h want=%h", n, obs_b, exp_b); end
            cycle(); n++;
        end
        Pause = 1'b0;
        checks++;
        if (n !== exp_done) begin errors++; $display("FAIL pause_done_time p0=%0d got=%0d want=%0d", p0, n, exp_done); end
        Start = 1'b0;
        cycle();
    endtask

    task automatic test_pause();
        pause_run(250, 50, 670);
        pause_run(101, 7, 627);
        pause_run(619, 5, 625);
    endtask

    task automatic test_abort();
        launch();
        repeat (300) begin
            checks++;
            if (obs_a !== exp_a) begin errors++; $display("FAIL abort_run_a got=%h want=%h", obs_a, exp_a); end
            cycle();
        end
        Start = 1'b0;
        cycle();
        checks++;
        if (obs_a !== 15'h0 || obs_b !== 15'h0) begin errors++; $display("FAIL abort_idle got=%h/%h want=0000", obs_a, obs_b); end
        launch();
        repeat (40) cycle();
        Reset = 1'b1;
        repeat (2) cycle();
        Reset = 1'b0;
        repeat (20) begin
            cycle();
            checks++;
            if (obs_a !== 15'h0 || obs_b !== 15'h0) begin errors++; $display("FAIL reset_norestart got=%h/%h want=0000", obs_a, obs_b); end
        end
        launch();
        checks++;
        if (busy_a !== 1'b1 || coils_a !== 4'b0001) begin errors++; $display("FAIL relaunch got=%h want busy=1 coils=1", obs_a); end
        repeat (30) cycle();
        Pause = 1'b1;
        Start = 1'b0;
        cycle();
        Pause = 1'b0;
        checks++;
        if (obs_a !== 15'h0 || busy_a !== 1'b0) begin errors++; $display("FAIL abort_beats_pause got=%h want=0000", obs_a); end
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 4; r++) begin
            HalfStep = 1'($urandom_range(0, 1));
            launch();
            n = 0;
            while (done_a !== 1'b1 && n < 900) begin
                Pause = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 29) == 0) HalfStep = ~HalfStep;
                if ($urandom_range(0, 799) == 0) Start = 1'b0;
                checks++;
                if (obs_a !== exp_a) begin errors++; $display("FAIL rand_a r=%0d n=%0d got=%h want=%h", r, n, obs_a, exp_a); end
                checks++;
                if (obs_b !== exp_b) begin errors++; $display("FAIL rand_b r=%0d n=%0d got=%h want=%h", r, n, obs_b, exp_b); end
                cycle(); n++;
            end
            Pause = 1'b0;
            Start = 1'b0;
            cycle();
            checks++;
            if (obs_a !== exp_a || obs_b !== exp_b) begin
                errors++; $display("FAIL rand_end r=%0d got=%h/%h want=%h/%h", r, obs_a, obs_b, exp_a, exp_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_step();
        test_half_step();
        test_pause();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wash_agitator_ctrl.md
Name: wash_agitator_ctrl

Overview:
Parametrised wash-phase agitation controller driving a 4-coil unipolar stepper. It runs a configurable number of alternating-direction agitation segments separated by coil-off dwell gaps. It supports full- or half-step drive, a programmable step-rate divider, pause/resume and abort. It replaces the fixed 600-tick wash stage in the washer sequencer and hands a level Done flag to the next stage (rinse).

Parameters:
NUM_SEG, 6, agitation segments per wash phase (>=1)
SEG_LEN, 100, CLK cycles of motor drive per segment (>=1)
DWELL_LEN, 4, CLK cycles of coils-off gap between segments (0 = immediate reversal)
STEP_DIV, 1, CLK cycles per motor step (>=1)
CNT_W, 16, width of internal cycle counters (must hold max of SEG_LEN, DWELL_LEN, STEP_DIV)

Ports:
CLK  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high; wins over all other inputs
Start  in  1  level run request; rising edge (sampled low then high) launches a phase, low aborts
Pause  in  1  level; high freezes the phase
HalfStep  in  1  1 = half-step, 0 = full-step; sampled at each segment start
Coils  out  4  stepper coil drive {D,C,B,A}
Reverse  out  1  direction of current/last segment (0 = forward)
Busy  out  1  high in RUN, DWELL or PAUSED
Done  out  1  phase complete; held until Start low
SegIdx  out  $clog2(NUM_SEG)+1  index of current segment, 0-based

Behaviour:
- Reset: state IDLE, Coils=0000, Reverse=0, Busy=0, Done=0, SegIdx=0, all counters 0, Start history cleared to 0.
- States: IDLE, RUN, DWELL, PAUSED, DONE.
- IDLE: Start rising edge sampled in cycle N -> RUN in N+1, SegIdx=0, Reverse=0, step index 0, Coils=0001 in N+1.
- Step table (8 entries, index 0..7): 0001,1001,1000,1100,0100,0110,0010,0011. Forward: index += (HalfStep?1:2) mod 8. Reverse: index -= (HalfStep?1:2) mod 8. Full-step therefore runs 0001,1000,0100,0010 (fwd) / 0001,0010,0100,1000 (rev). Index is reset to 0 at every segment start.
- RUN: step divider counts 0..STEP_DIV-1; index advances on the cycle the divider wraps. The segment counter counts SEG_LEN cycles. After the last cycle of a segment: if SegIdx==NUM_SEG-1 -> DONE; else if DWELL_LEN>0 -> DWELL; else go directly to next segment (SegIdx+1, Reverse toggled).
- DWELL: Coils=0000 for exactly DWELL_LEN cycles, then RUN with SegIdx+1, Reverse toggled, Coils=0001.
- Total active cycles = NUM_SEG*SEG_LEN + (NUM_SEG-1)*DWELL_LEN, excluding pauses. Done=1 on the first cycle after the last RUN cycle.
- PAUSED: entered from RUN/DWELL when Pause=1. All counters and Coils are frozen at their current values (holding torque in RUN, 0000 in DWELL). Pause=0 returns to the saved state next cycle and resumes exactly where it stopped. Each pause cycle delays Done by exactly one cycle.
- DONE: Coils=0000, Busy=0, Done=1. Start held high does not restart. Start low -> IDLE with Done=0 next cycle.
- Abort: Start=0 in RUN/DWELL/PAUSED -> IDLE next cycle, Coils=0000, Done=0, Reverse=0, SegIdx=0.
- Simultaneous events: Reset > Start-low abort > Pause > segment/phase end. Pause on the final cycle of a segment defers the transition until resume.
- Pause in IDLE/DONE is ignored. HalfStep changes mid-segment take effect at the next segment start.
- All outputs are registered; no combinational input-to-output paths.

Decomposition:
- Shared package wash_pkg: state enum type, 8-entry step-pattern constant array, coil-off constant 4'b0000.
- One sub-module: stepper_seq (index register, direction, full/half increment, divider tick in, Coils out). It is reusable by the spin-phase controller.

Test Plan:
- Defaults, full-step: Reset, then Start=1 -> Coils 0001,1000,0100,0010 repeating for 100 cycles, Reverse=0; Done rises exactly 620 cycles after RUN entry; Done held while Start=1; Start=0 -> Done=0 next cycle.
- Direction/dwell: observe cycles 100..104 -> Coils=0000 for 4 cycles; segment 1 -> Reverse=1, Coils 0001,0010,0100,1000; SegIdx increments 0..5.
- HalfStep=1, STEP_DIV=3 -> each of the 8 patterns is held 3 cycles, forward then reverse order; DWELL_LEN=0 -> reversal with no 0000 gap.
- Pause=1 for 50 cycles mid segment 2 -> Coils, SegIdx and Reverse frozen, Busy=1; Done arrives at cycle 670. Pause during DWELL -> Coils stay 0000 and dwell length is preserved.
- Start=0 at cycle 300 -> IDLE next cycle, Coils=0000, Busy=0. Reset=1 mid-run with Start=1 -> all outputs at reset values; no restart until Start goes low then high.
- Pause and Start=0 in the same cycle -> abort wins. Pause on the last segment cycle -> DONE deferred until Pause=0.
